// File: rtl/median_pkg.sv
// Shared constants for the 5x5 median filter stage.
// The kernel element layout is {dv, vs, hs, red, green, blue}, MSB first.
package median_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned PIX_W       = 3 * DATA_W + 3;
  localparam int unsigned KERNEL_N    = 25;
  localparam int unsigned CENTER_IDX  = 12;
  localparam int unsigned MEDIAN_RANK = 12;
  localparam int unsigned LATENCY     = 3;
  localparam int unsigned RANK_W      = 5;

  localparam int unsigned BLUE_LSB  = 0;
  localparam int unsigned GREEN_LSB = 8;
  localparam int unsigned RED_LSB   = 16;
  localparam int unsigned HS_BIT    = 24;
  localparam int unsigned VS_BIT    = 25;
  localparam int unsigned DV_BIT    = 26;

  typedef struct packed {
    logic dv;
    logic vs;
    logic hs;
  } sync_t;

endpackage

// File: rtl/median25.sv
// One colour channel of the 5x5 median: S1 ranks every element, S2 picks rank 12.
// Bypass and blank arrive with the S0 data and are carried alongside it.
module median25
  import median_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bypass_i,
  input  logic                       blank_i,
  input  logic [KERNEL_N*DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0]          med_o
);

  localparam logic [RANK_W-1:0] MED_R = RANK_W'(MEDIAN_RANK);

  logic [DATA_W-1:0] val_d  [KERNEL_N];
  logic [DATA_W-1:0] val_q  [KERNEL_N];
  logic [RANK_W-1:0] rank_d [KERNEL_N];
  logic [RANK_W-1:0] rank_q [KERNEL_N];
  logic              bypass_q;
  logic              blank_q;
  logic [DATA_W-1:0] sel;
  logic [DATA_W-1:0] med_d;
  logic [DATA_W-1:0] med_q;

  always_comb begin
    for (int unsigned i = 0; i < KERNEL_N; i++) begin
      val_d[i] = pix_i[i*DATA_W +: DATA_W];
    end
  end

  // Equal values are ordered by index so the 25 ranks form a permutation of 0..24.
  always_comb begin
    for (int unsigned i = 0; i < KERNEL_N; i++) begin
      rank_d[i] = '0;
      for (int unsigned j = 0; j < KERNEL_N; j++) begin
        if ((val_d[j] < val_d[i]) || ((j < i) && (val_d[j] == val_d[i]))) begin
          rank_d[i] = rank_d[i] + RANK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < KERNEL_N; i++) begin
        val_q[i]  <= '0;
        rank_q[i] <= '0;
      end
      bypass_q <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      val_q    <= val_d;
      rank_q   <= rank_d;
      bypass_q <= bypass_i;
      blank_q  <= blank_i;
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < KERNEL_N; i++) begin
      sel = sel | ({DATA_W{rank_q[i] == MED_R}} & val_q[i]);
    end
    if (blank_q) begin
      med_d = '0;
    end else if (bypass_q) begin
      med_d = val_q[CENTER_IDX];
    end else begin
      med_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      med_q <= '0;
    end else begin
      med_q <= med_d;
    end
  end

  assign med_o = med_q;

endmodule

// File: rtl/median5x5.sv
// 5x5 per-channel median filter, 3-cycle latency, one window per clock.
// Sync bits come from the centre element only and ride a matched delay line.
module median5x5
  import median_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [KERNEL_N*(3*DATA_W+3)-1:0]     kernel,
  output logic                                 tx_dv,
  output logic                                 tx_hs,
  output logic                                 tx_vs,
  output logic [DATA_W-1:0]                    tx_red,
  output logic [DATA_W-1:0]                    tx_green,
  output logic [DATA_W-1:0]                    tx_blue
);

  localparam int unsigned PW  = 3 * DATA_W + 3;
  localparam int unsigned CHW = KERNEL_N * DATA_W;

  logic [CHW-1:0] red_d, green_d, blue_d;
  logic [CHW-1:0] red_q, green_q, blue_q;
  logic           en_q;
  sync_t          sync_d, sync_s0_q, sync_s1_q, sync_s2_q;
  logic           unused_nbr_sync;

  // Only the colour fields of the neighbours are kept; their sync bits are dropped here.
  always_comb begin
    unused_nbr_sync = 1'b0;
    for (int unsigned i = 0; i < KERNEL_N; i++) begin
      blue_d[i*DATA_W +: DATA_W]  = kernel[i*PW +: DATA_W];
      green_d[i*DATA_W +: DATA_W] = kernel[i*PW + DATA_W +: DATA_W];
      red_d[i*DATA_W +: DATA_W]   = kernel[i*PW + 2*DATA_W +: DATA_W];
      if (i != CENTER_IDX) begin
        unused_nbr_sync = unused_nbr_sync ^ (^kernel[i*PW + 3*DATA_W +: 3]);
      end
    end
    sync_d = kernel[CENTER_IDX*PW + 3*DATA_W +: 3];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      en_q      <= 1'b0;
      sync_s0_q <= '0;
      sync_s1_q <= '0;
      sync_s2_q <= '0;
    end else begin
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      en_q      <= en;
      sync_s0_q <= sync_d;
      sync_s1_q <= sync_s0_q;
      sync_s2_q <= sync_s1_q;
    end
  end

  median25 #(.DATA_W(DATA_W)) u_red (
    .clk_i    (clk),
    .rst_ni   (rst),
    .bypass_i (~en_q),
    .blank_i  (~sync_s0_q.dv),
    .pix_i    (red_q),
    .med_o    (tx_red)
  );

  median25 #(.DATA_W(DATA_W)) u_green (
    .clk_i    (clk),
    .rst_ni   (rst),
    .bypass_i (~en_q),
    .blank_i  (~sync_s0_q.dv),
    .pix_i    (green_q),
    .med_o    (tx_green)
  );

  median25 #(.DATA_W(DATA_W)) u_blue (
    .clk_i    (clk),
    .rst_ni   (rst),
    .bypass_i (~en_q),
    .blank_i  (~sync_s0_q.dv),
    .pix_i    (blue_q),
    .med_o    (tx_blue)
  );

  assign tx_dv = sync_s2_q.dv;
  assign tx_vs = sync_s2_q.vs;
  assign tx_hs = sync_s2_q.hs;

endmodule

// File: tb/tb_median5x5.sv
// Directed bench for median5x5: vector table plus streaming sequences for
// sync alignment, per-window bypass toggling and asynchronous reset.
module tb_median5x5;

  localparam int unsigned PW = 27;
  localparam int unsigned KW = 25 * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [KW-1:0] kernel = '0;
  logic          tx_dv, tx_hs, tx_vs;
  logic [7:0]    tx_red, tx_green, tx_blue;
  logic [26:0]   outv;

  median5x5 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .kernel   (kernel),
    .tx_dv    (tx_dv),
    .tx_hs    (tx_hs),
    .tx_vs    (tx_vs),
    .tx_red   (tx_red),
    .tx_green (tx_green),
    .tx_blue  (tx_blue)
  );

  assign outv = {tx_dv, tx_vs, tx_hs, tx_red, tx_green, tx_blue};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] kr [25];
  logic [7:0] kg [25];
  logic [7:0] kb [25];
  logic [2:0] ks [25];  // {dv, vs, hs}

  typedef struct {
    string         name;
    logic [KW-1:0] k;
    logic          e;
    logic [26:0]   exp;
  } vec_t;

  vec_t          tbl [$];
  logic [KW-1:0] sk [64];
  logic          se [64];

  function automatic logic [KW-1:0] pack_k();
    logic [KW-1:0] k;
    for (int i = 0; i < 25; i++) k[i*PW +: PW] = {ks[i], kr[i], kg[i], kb[i]};
    return k;
  endfunction

  // Reference: sort each channel and take the 13th smallest.
  function automatic logic [26:0] model(input logic [KW-1:0] k, input logic e);
    logic [26:0] c, r;
    logic [7:0]  a [25];
    logic [7:0]  t;
    c = k[12*PW +: PW];
    r = '0;
    r[26:24] = c[26:24];
    if (c[26]) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int i = 0; i < 25; i++) a[i] = k[i*PW + ch*8 +: 8];
        for (int i = 1; i < 25; i++)
          for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
            t = a[j]; a[j] = a[j-1]; a[j-1] = t;
          end
        r[ch*8 +: 8] = e ? a[12] : c[ch*8 +: 8];
      end
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_flat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < 25; i++) begin
      kr[i] = r; kg[i] = g; kb[i] = b; ks[i] = 3'b000;
    end
    ks[12] = 3'b100;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 25; i++) begin
      kr[i] = 8'($urandom_range(0, 255));
      kg[i] = 8'($urandom_range(0, 255));
      kb[i] = 8'($urandom_range(0, 255));
      ks[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic add(input string nm, input logic e, input logic [26:0] exp);
    vec_t v;
    v.name = nm; v.k = pack_k(); v.e = e; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Caller is just after a rising edge; window t shows at the outputs in cycle t+3.
  task automatic stream(input int n, input bit zero_warm, input string nm);
    for (int t = 0; t < n; t++) begin
      kernel = sk[t];
      en     = se[t];
      @(negedge clk);
      if (t >= 3) check(nm, outv, model(sk[t-3], se[t-3]));
      else if (zero_warm) check({nm, "_warm"}, outv, 27'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int perm [25] = '{7, 19, 3, 24, 11, 0, 15, 22, 5, 13, 1, 18, 9, 20, 2,
                      16, 8, 23, 4, 14, 10, 21, 6, 17, 12};

    set_flat(8'h40, 8'h80, 8'hC0);
    add("flat", 1'b1, {3'b100, 8'h40, 8'h80, 8'hC0});

    for (int i = 0; i < 25; i++) begin
      kr[i] = 8'(perm[i]); kg[i] = 8'(24 - i); kb[i] = 8'(i * 10); ks[i] = 3'b000;
    end
    ks[12] = 3'b100;
    add("perm", 1'b1, {3'b100, 8'd12, 8'd12, 8'd120});

    set_flat(8'd100, 8'd100, 8'd100);
    kr[12] = 8'd255; kg[12] = 8'd255; kb[12] = 8'd255;
    add("salt", 1'b1, {3'b100, 8'd100, 8'd100, 8'd100});

    set_flat(8'd100, 8'd100, 8'd100);
    kr[0] = 8'd0; kg[0] = 8'd0; kb[0] = 8'd0;
    add("pepper", 1'b1, {3'b100, 8'd100, 8'd100, 8'd100});

    for (int i = 0; i < 25; i++) begin
      kr[i] = (i < 13) ? 8'd5 : 8'd200;
      kg[i] = (i < 12) ? 8'd5 : 8'd200;
      kb[i] = 8'd7;
      ks[i] = 3'b000;
    end
    ks[12] = 3'b101;
    add("ties", 1'b1, {3'b101, 8'd5, 8'd200, 8'd7});

    set_flat(8'hFF, 8'h00, 8'hFF);
    for (int i = 0; i < 12; i++) kb[i] = 8'h00;
    add("extremes", 1'b1, {3'b100, 8'hFF, 8'h00, 8'hFF});

    rand_win();
    ks[12] = 3'b011;
    add("dv0", 1'b1, {3'b011, 24'h000000});

    rand_win();
    kr[12] = 8'h12; kg[12] = 8'h34; kb[12] = 8'h56; ks[12] = 3'b100;
    add("bypass", 1'b0, {3'b100, 8'h12, 8'h34, 8'h56});

    rand_win();
    kr[12] = 8'h12; kg[12] = 8'h34; kb[12] = 8'h56; ks[12] = 3'b000;
    add("bypass_blank", 1'b0, 27'd0);

    for (int n = 0; n < 3; n++) begin
      rand_win();
      ks[12][2] = 1'b1;
      add("rand", 1'b1, model(pack_k(), 1'b1));
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", outv, 27'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (tbl[v]) begin
      kernel = tbl[v].k;
      en     = tbl[v].e;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(tbl[v].name, outv, tbl[v].exp);
      @(posedge clk);
      #1;
    end

    // Centre hs high in cycles 10..13, vs in cycle 20; neighbour sync bits random
    for (int t = 0; t < 30; t++) begin
      set_flat(8'h40, 8'h80, 8'hC0);
      for (int i = 0; i < 25; i++) ks[i] = 3'($urandom_range(0, 7));
      ks[12] = {1'b1, (t == 20), (t >= 10 && t <= 13)};
      sk[t] = pack_k();
      se[t] = 1'b1;
    end
    stream(30, 1'b0, "sync");

    for (int t = 0; t < 20; t++) begin
      rand_win();
      ks[12][2] = ($urandom_range(0, 3) != 0);
      sk[t] = pack_k();
      se[t] = t[0];
    end
    stream(20, 1'b0, "en_toggle");

    for (int t = 0; t < 8; t++) begin
      rand_win();
      ks[12][2] = 1'b1;
      sk[t] = pack_k();
      se[t] = 1'b1;
    end
    stream(8, 1'b0, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", outv, 27'd0);
    @(posedge clk);
    #1;
    check("rst_hold", outv, 27'd0);

    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin
      rand_win();
      ks[12][2] = 1'b1;
      sk[t] = pack_k();
      se[t] = 1'b1;
    end
    stream(10, 1'b1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/median5x5.md
# median5x5

Per-pixel 5×5 median filter stage that consumes the 25-pixel kernel window produced by the HDMI line-buffer stage and emits one filtered RGB pixel per clock, with DV/HSYNC/VSYNC realigned to the filtered data. It sits directly between the kernel buffer and the HDMI transmitter. The block is fully pipelined with a fixed latency of 3 cycles and no back-pressure. Each colour channel is filtered independently.

## Interface
- DATA_W, 8, bits per colour channel.
- PIX_W, 3*DATA_W+3 (27), kernel element width: {dv, vs, hs, red, green, blue}, MSB first.
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  1 = median output, 0 = bypass (centre pixel passed through with the same latency).
- kernel  in  25*PIX_W  flattened window. Element (row r, col c) is at bits [(5r+c)*PIX_W +: PIX_W], r,c ∈ 0..4. The centre element is (2,2), index 12.
- tx_dv  out  1  centre-element dv, delayed 3 cycles.
- tx_hs  out  1  centre-element hs, delayed 3 cycles.
- tx_vs  out  1  centre-element vs, delayed 3 cycles.
- tx_red, tx_green, tx_blue  out  DATA_W each  filtered channel values.

## Operation
- S0: register `kernel` and `en`. There is no enable or valid gating, so a new window is accepted every cycle.
- S1, per channel, for each element i:
  - rank_i = #{j : v_j < v_i} + #{j < i : v_j == v_i}.
  - The rank is 5 bits, range 0..24.
  - Register the 25 ranks and 25 values.
- S2, per channel:
  - Select the element with rank_i == 12. The tie-break guarantees exactly one match.
  - Register the selected value to the output.
  - The select is a one-hot OR mux. A priority encoder is not required.
- Bypass (S0 en = 0): the S2 output is the centre element's channel value instead of the median. `en` is pipelined alongside the data, so toggling it affects only the windows it is sampled with.
- Blanking: if the centre dv delayed to S2 is 0, tx_red/green/blue = 0, regardless of en.
- Sync bits (dv, vs, hs) are taken only from element 12 and delayed through 3 registers matched to the data path. No sync decoding is done.
- Image borders: no special handling. The window content supplied upstream is filtered as-is.
- Arithmetic: comparisons are unsigned on DATA_W bits. Rank adders are 5-bit and cannot overflow (maximum 24).

## Timing
- Latency: window presented at edge n → outputs valid after edge n+3. Throughput is 1 window per clock.
- Reset (rst low, asynchronous): all pipeline registers clear immediately. tx_* = 0 while reset is asserted.
- After rst deasserts, the first 3 output cycles show cleared pipeline contents (all zero). Valid data follows.
- Reset asserted mid-frame: outputs drop to 0 on assertion, with no partial pixel emitted. Recovery is as above.
- No handshake. The consumer samples every cycle and treats tx_dv as the data qualifier.

## Structure
- Shared package median_pkg:
  - KERNEL_N = 25, CENTER_IDX = 12, MEDIAN_RANK = 12, LATENCY = 3.
  - Field offsets within PIX_W: BLUE_LSB = 0, GREEN_LSB = 8, RED_LSB = 16, HS_BIT = 24, VS_BIT = 25, DV_BIT = 26.
- Sub-module median25: one channel, covering the S1 rank and S2 select stages on 25 × DATA_W inputs. It takes clk and rst, and inputs for bypass and blank.
- The top level instantiates median25 three times, owns the S0 register and the sync delay line, and unpacks `kernel`.

## Test plan
- Flat field: all 25 elements RGB = 0x40/0x80/0xC0, centre dv = 1, en = 1 → RGB = 0x40/0x80/0xC0 three cycles later. Exercises the all-ties tie-break.
- Permutation: red = 25 distinct values 0..24 in shuffled order, green = reversed, blue = i*10 → red = 12, green = 12, blue = 120.
- Salt-and-pepper: 24 elements = 100, centre = 255 (and separately, one corner = 0) → output 100 on all channels.
- Sync alignment:
  - Centre hs high for cycles 10–13, vs high at cycle 20, with other elements' sync bits randomised → tx_hs high for 13–16 and tx_vs at 23.
  - Centre dv = 0 → RGB = 0.
- Bypass: en = 0, centre RGB = 0x12/0x34/0x56, neighbours random → output 0x12/0x34/0x56 at +3. Toggling en every cycle selects per window.
- Reset: stream random windows, pull rst low mid-cycle → all tx_* = 0 before the next edge. Release → 3 zero cycles, then a match with the golden model.
